// File: rtl/biriscv_regfile_mp_pkg.sv
// biriscv_defs: shared register-file constants, default geometry and packed-port slice helper
`ifndef BIRISCV_SLICE
`define BIRISCV_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif
package biriscv_defs;
  localparam int REG_ZERO     = 0;
  localparam int DEF_NUM_RD   = 4;
  localparam int DEF_NUM_WR   = 2;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  function automatic int lvt_width(input int num_wr);
    return (num_wr > 1) ? $clog2(num_wr) : 1;
  endfunction
endpackage

// File: rtl/biriscv_regfile_bank.sv
// biriscv_regfile_bank: one-write, NUM_RD async-read storage bank with no reset (maps to LUTRAM)
module biriscv_regfile_bank
  import biriscv_defs::*;
#(
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS)
)(
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  // storage write; contents are qualified by the owner's valid bitmap, so no reset is needed
  always_ff @(posedge clk_i)
    if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
  genvar j;
  for (j = 0; j < NUM_RD; j++) begin : g_rd
    assign `BIRISCV_SLICE(rd_data_o, j, DATA_W) = r_mem[`BIRISCV_SLICE(rd_addr_i, j, ADDR_W)];
  end
endmodule

// File: rtl/biriscv_regfile_mp.sv
// biriscv_regfile_mp: NUM_WR-write / NUM_RD-read register file built from per-port banks plus a live-value table; define BIRISCV_REGFILE_BYPASS_EN for same-cycle write-through reads
module biriscv_regfile_mp
  import biriscv_defs::*;
#(
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS)
)(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o
);
  localparam int LVT_W = lvt_width(NUM_WR);
  logic [NUM_WR-1:0]        w_we;
  logic [ADDR_W-1:0]        w_waddr   [NUM_WR];
  logic [DATA_W-1:0]        w_wdata   [NUM_WR];
  logic [NUM_RD*DATA_W-1:0] w_bank_rd [NUM_WR];
  logic [ADDR_W-1:0]        w_raddr   [NUM_RD];
  logic [NUM_REGS-1:0]      r_valid;
  logic [LVT_W-1:0]         r_lvt     [NUM_REGS];
  genvar k, j;
  for (k = 0; k < NUM_WR; k++) begin : g_wr
    assign w_waddr[k] = `BIRISCV_SLICE(wr_addr_i, k, ADDR_W);
    assign w_wdata[k] = `BIRISCV_SLICE(wr_data_i, k, DATA_W);
    assign w_we[k]    = wr_en_i[k] && (w_waddr[k] != ADDR_W'(REG_ZERO));
    biriscv_regfile_bank #(
      .NUM_RD   (NUM_RD),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
    ) u_bank (
      .clk_i     (clk_i),
      .wr_en_i   (w_we[k]),
      .wr_addr_i (w_waddr[k]),
      .wr_data_i (w_wdata[k]),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (w_bank_rd[k])
    );
  end
  // live-value table and valid bitmap; ascending loop lets the youngest (highest) port win a collision
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_valid <= '0;
      r_lvt   <= '{default: '0};
    end else begin
      for (int i = 0; i < NUM_WR; i++)
        if (w_we[i]) begin
          r_valid[w_waddr[i]] <= 1'b1;
          r_lvt[w_waddr[i]]   <= LVT_W'(i);
        end
    end
  for (j = 0; j < NUM_RD; j++) begin : g_rd
    logic [DATA_W-1:0] w_rd;
    assign w_raddr[j] = `BIRISCV_SLICE(rd_addr_i, j, ADDR_W);
    // pick the bank named by the LVT, zero-gate x0 / never-written registers, optional write-through
    always_comb begin
      w_rd = '0;
      if (w_raddr[j] != ADDR_W'(REG_ZERO) && r_valid[w_raddr[j]])
        for (int i = 0; i < NUM_WR; i++)
          if (r_lvt[w_raddr[j]] == LVT_W'(i)) w_rd = `BIRISCV_SLICE(w_bank_rd[i], j, DATA_W);
`ifdef BIRISCV_REGFILE_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++)
        if (w_we[i] && w_waddr[i] == w_raddr[j]) w_rd = w_wdata[i];
`endif
      if (rst_i) w_rd = '0;
    end
    assign `BIRISCV_SLICE(rd_data_o, j, DATA_W) = w_rd;
  end
endmodule

// File: doc/biriscv_regfile_mp.md
# biriscv_regfile_mp

Parametrised multi-port integer register file: NUM_WR synchronous write ports, NUM_RD asynchronous read ports, x0 hard-wired to zero. Built as one 1-write/NUM_RD-read bank per write port plus a live-value table (LVT) that records which bank holds the newest copy of each register. It is the drop-in register file for the dual-issue pipeline, where the default 4R2W configuration serves two issue slots' rs1/rs2 reads and two writeback ports. Unlike the previous 2R1W file, reset leaves every register reading zero.

## Interface
- NUM_RD, default 4: read ports, 1..8.
- NUM_WR, default 2: write ports, 1..4; higher index is younger in program order.
- DATA_W, default 32: register width.
- NUM_REGS, default 32: register count, power of two, 2..64.
- ADDR_W, default $clog2(NUM_REGS): address width, derived, never overridden.
- clk_i  in  1  sole clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W].
- wr_data_i  in  NUM_WR*DATA_W  write data, port k at [k*DATA_W +: DATA_W].
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses, packed the same way.
- rd_data_o  out  NUM_RD*DATA_W  read data, combinational from rd_addr_i and state.

## Operation
- Effective write on port k: wr_en_i[k] and wr_addr_i[k] != 0. Writes to x0 are dropped.
- Each effective write does three things at the edge: bank k stores the data at the address, LVT[addr] <= k, and valid[addr] <= 1.
- Same address from several ports in one cycle: the highest k wins for both the LVT and the returned value. Lower-port bank contents may also update; that is harmless because the LVT points past them.
- Read port j:
  - rd_addr == 0 returns 0.
  - !valid[rd_addr] returns 0.
  - Otherwise returns bank[LVT[rd_addr]][rd_addr].
- Reset clears valid[] and LVT[] to 0 asynchronously. Bank storage is not reset (LUTRAM), so the valid bitmap is what makes every register read 0 after reset.
- Reset asserted mid-cycle with a write pending: the write is lost, and the register reads 0 after reset.
- rd_data_o during reset: all zeros.
- No handshake: a write is always accepted and a read is always served.

## Timing
- Write latency: data presented in cycle N is readable combinationally in cycle N+1, after the edge.
- Same-cycle read of an address being written: behaviour depends on the bypass macro, see Configuration.
- Read path depth: address -> bank LUT read, in parallel with LVT lookup, -> NUM_WR:1 mux -> zero gating.
- No pipeline registers and no stalls.

## Configuration
- BIRISCV_REGFILE_BYPASS_EN defined: a read whose address matches an effective write in the same cycle returns that write's wr_data_i, highest matching port winning. This is write-through.
- BIRISCV_REGFILE_BYPASS_EN undefined: a same-cycle read returns the pre-edge value, which is 0 if the register has not been written since reset.

## Structure
- Shared package/header (biriscv_defs) holds:
  - REG_ZERO address constant;
  - default NUM_RD / NUM_WR / DATA_W;
  - the packed-port slice helper macros.
- Sub-module biriscv_regfile_bank: one write port, NUM_RD async read ports, NUM_REGS x DATA_W, no reset. Instantiated NUM_WR times.
- Top level owns the LVT (NUM_REGS x $clog2(NUM_WR) flops), the valid bitmap, the read muxes and the bypass logic.

## Test plan
- Reset, then read all 32 addresses on all 4 ports -> every rd_data_o = 0. Write x5 = 0xDEADBEEF on port 0 -> next cycle, x5 reads 0xDEADBEEF on every read port.
- Same cycle: port 0 writes x7 = 0x11111111, port 1 writes x7 = 0x22222222 -> x7 reads 0x22222222. Next cycle port 0 alone writes x7 = 0x33333333 -> x7 reads 0x33333333, proving the LVT switched back to bank 0.
- Write x0 = 0xFFFFFFFF on both ports -> x0 reads 0 and no other register changes.
- Read x9 while writing x9 = 0x0000ABCD:
  - macro defined -> 0x0000ABCD in the same cycle;
  - undefined -> old value (0 after reset), then 0x0000ABCD next cycle.
- Write x3 = 0x12345678 and x4 = 0x9ABCDEF0, then pulse rst_i asynchronously between edges -> x3 and x4 read 0 immediately. After release, x3 = 0x55 on port 1 -> x3 reads 0x55 while x4 still reads 0.
- Random regression against a reference array model with NUM_WR = 1, NUM_RD = 2 and with NUM_WR = 3, NUM_RD = 6, 10k cycles, random enables and colliding addresses -> zero mismatches.
